sat_pack: RTL and testbench

Saturating narrower and packer: the inverse of the registered 2-bit-to-8-bit sign extender. It accepts a stream of 8-bit two's-complement samples and clips each to the 2-bit signed range (-2..+1). It packs LANES consecutive 2-bit fields into one output word and hands the word downstream over a valid/ready handshake. It sits on the datapath wherever 8-bit internal values return to a packed 2-bit storage or transport format.

---
 rtl/sat_pack.sv | 134 +++++++++++++
 tb/tb_sat_pack.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_pack.sv
// Saturating 8-bit -> 2-bit narrower that packs LANES fields per word behind a valid/ready output register.
// Optional clipping is enabled by defining SAT_PACK_SAT_EN; otherwise fields are plain truncations.
module sat_pack #(
    parameter int unsigned LANES = 4
) (
    input  logic               Clk,
    input  logic               Clear_n,
    input  logic [7:0]         in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [2*LANES-1:0] out,
    output logic [3:0]         out_cnt,
    output logic               out_sat,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int unsigned W    = 2 * LANES;
    localparam logic [3:0]  LAST = 4'(LANES - 1);
    localparam logic [3:0]  FULL = 4'(LANES);

    logic [W-1:0] acc_q, acc_d, acc_m;
    logic [3:0]   fill_q, fill_d, fill_m;
    logic         pend_q, pend_d;
    logic [W-1:0] out_q, out_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         vld_q, vld_d;
    logic [1:0]   field;
    logic         free, accept, flush_req, emit;

`ifdef SAT_PACK_SAT_EN
    logic clip_now, clip_q, clip_d, clip_m, sat_q, sat_d;

    always_comb begin
        field    = in[1:0];
        clip_now = 1'b0;
        if ($signed(in) > 8'sd1) begin
            field    = 2'b01;
            clip_now = 1'b1;
        end else if ($signed(in) < -8'sd2) begin
            field    = 2'b10;
            clip_now = 1'b1;
        end
    end
`else
    assign field = in[1:0];
`endif

    assign free     = !vld_q || out_ready;
    // Last lane can only be taken when the finished word has somewhere to go.
    assign in_ready = Clear_n && !pend_q && ((fill_q < LAST) || free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_m  = acc_q;
        fill_m = fill_q;
        if (accept) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (fill_q == 4'(k)) acc_m[2*k +: 2] = field;
            end
            fill_m = fill_q + 4'd1;
        end
    end

    always_comb begin
        acc_d     = acc_m;
        fill_d    = fill_m;
        pend_d    = pend_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        vld_d     = vld_q && !out_ready;
        emit      = 1'b0;
        flush_req = pend_q || (flush && (fill_m != 4'd0));
        if (fill_m == FULL) begin
            emit = 1'b1;
        end else if (flush_req && free) begin
            emit = 1'b1;
        end else if (flush_req) begin
            pend_d = 1'b1;
        end
        if (emit) begin
            out_d  = acc_m;
            cnt_d  = fill_m;
            vld_d  = 1'b1;
            acc_d  = '0;
            fill_d = '0;
            pend_d = 1'b0;
        end
    end

`ifdef SAT_PACK_SAT_EN
    always_comb begin
        clip_m = clip_q || (accept && clip_now);
        clip_d = emit ? 1'b0 : clip_m;
        sat_d  = emit ? clip_m : sat_q;
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            clip_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            clip_q <= clip_d;
            sat_q  <= sat_d;
        end
    end

    assign out_sat = sat_q;
`else
    assign out_sat = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            acc_q  <= '0;
            fill_q <= '0;
            pend_q <= 1'b0;
            out_q  <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            pend_q <= pend_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    assign out       = out_q;
    assign out_cnt   = cnt_q;
    assign out_valid = vld_q;
endmodule

// File: tb/tb_sat_pack.sv
// Directed self-checking bench for sat_pack (LANES=4); expectations follow SAT_PACK_SAT_EN.
module tb_sat_pack;
    logic       Clk = 1'b0;
    logic       Clear_n = 1'b0;
    logic [7:0] in = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [7:0] out;
    logic [3:0] out_cnt;
    logic       out_sat;
    logic       out_valid;
    logic       out_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    sat_pack #(.LANES(4)) dut (
        .Clk(Clk), .Clear_n(Clear_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out(out), .out_cnt(out_cnt), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        Clear_n = 1'b0;
        #2;
        checks++;
        if ({out, out_cnt, out_sat, out_valid} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got out=%h cnt=%0d sat=%b vld=%b exp all zero", out, out_cnt, out_sat, out_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        tick();
        Clear_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        send(8'h01);
        send(8'hFF);
        send(8'hFE);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_early_valid got %b exp 0", out_valid);
        end
        send(8'h00);
        checks++;
        if ({out_valid, out, out_cnt, out_sat} !== {1'b1, 8'h2D, 4'd4, 1'b0}) begin
            failures++;
            $display("FAIL full_word got vld=%b out=%h cnt=%0d sat=%b exp vld=1 out=2d cnt=4 sat=0",
                     out_valid, out, out_cnt, out_sat);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_valid_one_cycle got %b exp 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_out;
        logic       exp_sat;
`ifdef SAT_PACK_SAT_EN
        exp_out = 8'h99;
        exp_sat = 1'b1;
`else
        exp_out = 8'h63;
        exp_sat = 1'b0;
`endif
        send(8'h7F);
        send(8'h80);
        send(8'h02);
        send(8'hFD);
        checks++;
        if ({out_valid, out, out_cnt, out_sat} !== {1'b1, exp_out, 4'd4, exp_sat}) begin
            failures++;
            $display("FAIL sat_word got vld=%b out=%h cnt=%0d sat=%b exp vld=1 out=%h cnt=4 sat=%b",
                     out_valid, out, out_cnt, out_sat, exp_out, exp_sat);
        end
        tick();
    endtask

    task automatic test_flush();
        send(8'h01);
        send(8'h01);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({out_valid, out, out_cnt, out_sat} !== {1'b1, 8'h05, 4'd2, 1'b0}) begin
            failures++;
            $display("FAIL flush_word got vld=%b out=%h cnt=%0d sat=%b exp vld=1 out=05 cnt=2 sat=0",
                     out_valid, out, out_cnt, out_sat);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL flush_empty got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(8'h01); send(8'h01); send(8'h01); send(8'h01);
        checks++;
        if ({out_valid, out} !== {1'b1, 8'h55}) begin
            failures++;
            $display("FAIL bp_word1 got vld=%b out=%h exp vld=1 out=55", out_valid, out);
        end
        send(8'h00); send(8'hFF); send(8'hFE);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_drop got %b exp 0", in_ready);
        end
        checks++;
        if ({out_valid, out, out_cnt} !== {1'b1, 8'h55, 4'd4}) begin
            failures++;
            $display("FAIL bp_hold got vld=%b out=%h cnt=%0d exp vld=1 out=55 cnt=4", out_valid, out, out_cnt);
        end
        in = 8'h01;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_on_drain got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out, out_cnt} !== {1'b1, 8'h6C, 4'd4}) begin
            failures++;
            $display("FAIL bp_word2 got vld=%b out=%h cnt=%0d exp vld=1 out=6c cnt=4", out_valid, out, out_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain_done got %b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        out_ready = 1'b0;
        send(8'h01); send(8'h01); send(8'h01); send(8'h01);
        send(8'hFF); send(8'hFF);
        Clear_n = 1'b0;
        #1;
        checks++;
        if ({out, out_cnt, out_sat, out_valid, in_ready} !== 15'd0) begin
            failures++;
            $display("FAIL mid_reset got out=%h cnt=%0d sat=%b vld=%b rdy=%b exp all zero",
                     out, out_cnt, out_sat, out_valid, in_ready);
        end
        tick();
        Clear_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send(8'h00); send(8'h01);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_fill_cleared got vld=%b exp 0", out_valid);
        end
        send(8'hFF); send(8'hFE);
        checks++;
        if ({out_valid, out, out_cnt} !== {1'b1, 8'hB4, 4'd4}) begin
            failures++;
            $display("FAIL mid_reset_fresh got vld=%b out=%h cnt=%0d exp vld=1 out=b4 cnt=4", out_valid, out, out_cnt);
        end
        tick();
    endtask

    task automatic test_pending_flush();
        out_ready = 1'b0;
        send(8'h01); send(8'h01); send(8'h01); send(8'h01);
        send(8'hFF);
        in = 8'hFE;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        checks++;
        if ({in_ready, out_valid, out} !== {1'b0, 1'b1, 8'h55}) begin
            failures++;
            $display("FAIL pend_set got rdy=%b vld=%b out=%h exp rdy=0 vld=1 out=55", in_ready, out_valid, out);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL pend_hold got rdy=%b exp 0", in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, out, out_cnt, out_sat, in_ready} !== {1'b1, 8'h0B, 4'd2, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL pend_emit got vld=%b out=%h cnt=%0d sat=%b rdy=%b exp vld=1 out=0b cnt=2 sat=0 rdy=1",
                     out_valid, out, out_cnt, out_sat, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_done got vld=%b exp 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_saturate();
        test_flush();
        test_back_to_back();
        test_reset_mid_word();
        test_pending_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
